// File: rtl/repl_pkg.sv
// Shared replacement-policy types for cache and TLB victim selection.
// Holds the FSM state encoding, a safe way-width helper and the response record.
package repl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PICK,
    SCAN,
    DONE
  } victim_state_e;

  // Widest way index any consumer is expected to carry (up to 256 ways).
  localparam int REPL_WAY_W_MAX = 8;

  // Way-index width that never collapses to zero bits.
  function automatic int way_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [REPL_WAY_W_MAX-1:0] way;
    logic                      hit_invalid;
    logic                      none;
  } victim_resp_t;

endpackage

// File: rtl/prio_enc_lsb.sv
// Lowest-set-bit priority encoder with an any-bit flag.
// Used to pick the lowest-numbered free way.
module prio_enc_lsb
  import repl_pkg::*;
#(
  parameter int N = 4,
  localparam int W = way_width(N)
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  always_comb begin
    o_idx = '0;
    // Walk from the top down so the lowest set bit wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = W'(i);
      end
    end
  end

  assign o_any = |i_vec;

endmodule

// File: rtl/rand_victim_sel.sv
// Replacement-victim picker: invalid unlocked way first, else a random unlocked way.
// Drives the LFSR advance pulse on accept and answers over a valid/ready handshake.
module rand_victim_sel
  import repl_pkg::*;
#(
  parameter int WAYS   = 4,
  parameter int RAND_W = 32,
  localparam int WAY_W = way_width(WAYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WAYS-1:0]   valid_mask,
  input  logic [WAYS-1:0]   lock_mask,
  input  logic [RAND_W-1:0] randnum,
  output logic              rand_en,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WAY_W-1:0]  resp_way,
  output logic              resp_hit_invalid,
  output logic              resp_none
);

  victim_state_e    r_state;
  logic [WAYS-1:0]  r_valid_q;
  logic [WAYS-1:0]  r_lock_q;
  logic [WAY_W-1:0] r_idx;
  logic [WAY_W-1:0] r_way;
  logic             r_resp_valid;
  logic             r_hit_invalid;
  logic             r_none;

  logic [WAYS-1:0]  w_free;
  logic [WAYS-1:0]  w_avail;
  logic [WAY_W-1:0] w_free_idx;
  logic             w_free_any;
  logic [WAY_W-1:0] w_rand_idx;
  logic             w_accept;
  logic             w_unused_rand;

  assign w_free     = ~r_valid_q & ~r_lock_q;
  assign w_avail    = ~r_lock_q;
  assign w_rand_idx = randnum[WAY_W-1:0];
  // Only the low bits select a way; the rest of the LFSR word is ignored.
  assign w_unused_rand = ^randnum[RAND_W-1:WAY_W];

  assign req_ready = (r_state == IDLE);
  assign w_accept  = req_valid && req_ready && !rst;
  assign rand_en   = w_accept;

  assign resp_valid       = r_resp_valid;
  assign resp_way         = r_way;
  assign resp_hit_invalid = r_hit_invalid;
  assign resp_none        = r_none;

  prio_enc_lsb #(
    .N(WAYS)
  ) u_free_enc (
    .i_vec(w_free),
    .o_idx(w_free_idx),
    .o_any(w_free_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_valid_q     <= '0;
      r_lock_q      <= '0;
      r_idx         <= '0;
      r_way         <= '0;
      r_resp_valid  <= 1'b0;
      r_hit_invalid <= 1'b0;
      r_none        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_valid_q <= valid_mask;
            r_lock_q  <= lock_mask;
            r_state   <= PICK;
          end
        end
        PICK: begin
          if (w_free_any) begin
            r_way         <= w_free_idx;
            r_hit_invalid <= 1'b1;
            r_none        <= 1'b0;
            r_resp_valid  <= 1'b1;
            r_state       <= DONE;
          end else if (w_avail == '0) begin
            r_way         <= '0;
            r_hit_invalid <= 1'b0;
            r_none        <= 1'b1;
            r_resp_valid  <= 1'b1;
            r_state       <= DONE;
          end else if (w_avail[w_rand_idx]) begin
            r_way         <= w_rand_idx;
            r_hit_invalid <= 1'b0;
            r_none        <= 1'b0;
            r_resp_valid  <= 1'b1;
            r_state       <= DONE;
          end else begin
            r_idx   <= w_rand_idx + WAY_W'(1);
            r_state <= SCAN;
          end
        end
        SCAN: begin
          // At least one unlocked way exists here, so this walk always ends.
          if (w_avail[r_idx]) begin
            r_way         <= r_idx;
            r_hit_invalid <= 1'b0;
            r_none        <= 1'b0;
            r_resp_valid  <= 1'b1;
            r_state       <= DONE;
          end else begin
            r_idx <= r_idx + WAY_W'(1);
          end
        end
        DONE: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rand_victim_sel.sv
// Directed bench for rand_victim_sel with WAYS=4: policy, latency, backpressure, reset.
module tb_rand_victim_sel;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  valid_mask;
  logic [3:0]  lock_mask;
  logic [31:0] randnum;
  logic        rand_en;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_way;
  logic        resp_hit_invalid;
  logic        resp_none;

  int n_cmp = 0;
  int n_err = 0;

  rand_victim_sel #(
    .WAYS(4),
    .RAND_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .valid_mask(valid_mask),
    .lock_mask(lock_mask),
    .randnum(randnum),
    .rand_en(rand_en),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_way(resp_way),
    .resp_hit_invalid(resp_hit_invalid),
    .resp_none(resp_none)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request with resp_ready held high; masks are scrambled after accept.
  task automatic do_req(input string tag, input logic [3:0] vm, input logic [3:0] lm,
                        input logic [31:0] rnd, input logic [1:0] ew, input logic eh,
                        input logic en, input int elat);
    int c;
    bit saw_en;
    tick();
    req_valid  = 1'b1;
    valid_mask = vm;
    lock_mask  = lm;
    randnum    = rnd;
    resp_ready = 1'b1;
    #1;
    chk_val({tag, "_acc_ready"}, req_ready, 1);
    chk_val({tag, "_acc_en"}, rand_en, 1);
    tick();
    req_valid  = 1'b0;
    valid_mask = ~vm;
    lock_mask  = ~lm;
    #1;
    c = 1;
    saw_en = 1'b0;
    while (!resp_valid && c < 20) begin
      if (rand_en) saw_en = 1'b1;
      tick();
      #1;
      c++;
    end
    if (rand_en) saw_en = 1'b1;
    chk_val({tag, "_valid"}, resp_valid, 1);
    chk_val({tag, "_lat"}, c, elat);
    chk_val({tag, "_way"}, resp_way, ew);
    chk_val({tag, "_hit"}, resp_hit_invalid, eh);
    chk_val({tag, "_none"}, resp_none, en);
    chk_val({tag, "_no_en"}, saw_en, 0);
    $display("txn %s: way=%0d hit_invalid=%0b none=%0b latency=%0d", tag, resp_way,
             resp_hit_invalid, resp_none, c);
    tick();
    #1;
    chk_val({tag, "_idle_valid"}, resp_valid, 0);
    chk_val({tag, "_idle_ready"}, req_ready, 1);
  endtask

  initial begin
    bit seen;
    rst        = 1'b1;
    req_valid  = 1'b1;
    valid_mask = 4'b0000;
    lock_mask  = 4'b0000;
    randnum    = 32'h0;
    resp_ready = 1'b0;

    repeat (3) tick();
    #1;
    chk_val("rst_rand_en", rand_en, 0);
    chk_val("rst_resp_valid", resp_valid, 0);
    chk_val("rst_way", resp_way, 0);
    chk_val("rst_hit", resp_hit_invalid, 0);
    chk_val("rst_none", resp_none, 0);
    rst       = 1'b0;
    req_valid = 1'b0;
    tick();
    #1;
    chk_val("rst_ready_after", req_ready, 1);
    $display("txn reset: req_ready=%0b resp_valid=%0b", req_ready, resp_valid);

    do_req("free",    4'b1011, 4'b0000, 32'h0000_0000, 2'd2, 1'b1, 1'b0, 2);
    do_req("random",  4'b1111, 4'b0000, 32'hABCD_0001, 2'd1, 1'b0, 1'b0, 2);
    do_req("scanwrap",4'b1111, 4'b1011, 32'h0000_0003, 2'd2, 1'b0, 1'b0, 5);
    do_req("lockinv", 4'b0111, 4'b1000, 32'h0000_0003, 2'd0, 1'b0, 1'b0, 3);
    do_req("alllock", 4'b0000, 4'b1111, 32'h0000_0002, 2'd0, 1'b0, 1'b1, 2);
    do_req("rand0",   4'b1111, 4'b0000, 32'h0000_0000, 2'd0, 1'b0, 1'b0, 2);

    // Backpressure: result held while the next request waits at the door.
    tick();
    req_valid  = 1'b1;
    valid_mask = 4'b1111;
    lock_mask  = 4'b0000;
    randnum    = 32'h0000_0002;
    resp_ready = 1'b0;
    #1;
    chk_val("bp_acc_en", rand_en, 1);
    tick();
    valid_mask = 4'b1110;
    #1;
    chk_val("bp_pick_ready", req_ready, 0);
    chk_val("bp_pick_en", rand_en, 0);
    tick();
    #1;
    chk_val("bp_valid", resp_valid, 1);
    chk_val("bp_way", resp_way, 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk_val("bp_hold_valid", resp_valid, 1);
      chk_val("bp_hold_way", resp_way, 2);
      chk_val("bp_hold_hit", resp_hit_invalid, 0);
      chk_val("bp_hold_ready", req_ready, 0);
      chk_val("bp_hold_en", rand_en, 0);
    end
    $display("txn backpressure1: way=%0d held", resp_way);
    resp_ready = 1'b1;
    tick();
    #1;
    chk_val("bp_next_valid", resp_valid, 0);
    chk_val("bp_next_ready", req_ready, 1);
    chk_val("bp_next_en", rand_en, 1);
    tick();
    req_valid = 1'b0;
    #1;
    tick();
    #1;
    chk_val("bp2_valid", resp_valid, 1);
    chk_val("bp2_way", resp_way, 0);
    chk_val("bp2_hit", resp_hit_invalid, 1);
    $display("txn backpressure2: way=%0d hit_invalid=%0b", resp_way, resp_hit_invalid);
    tick();
    #1;
    chk_val("bp2_done", resp_valid, 0);

    // Reset while scanning drops the request.
    tick();
    req_valid  = 1'b1;
    valid_mask = 4'b1111;
    lock_mask  = 4'b0111;
    randnum    = 32'h0000_0000;
    resp_ready = 1'b1;
    #1;
    chk_val("rstscan_acc_en", rand_en, 1);
    tick();
    req_valid = 1'b0;
    #1;
    tick();
    #1;
    chk_val("rstscan_in_scan", resp_valid, 0);
    chk_val("rstscan_busy", req_ready, 0);
    rst = 1'b1;
    tick();
    #1;
    chk_val("rstscan_valid", resp_valid, 0);
    chk_val("rstscan_ready", req_ready, 1);
    chk_val("rstscan_en", rand_en, 0);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      #1;
      if (resp_valid) seen = 1'b1;
    end
    chk_val("rstscan_no_resp", seen, 0);
    $display("txn rst_in_scan: response_seen=%0b", seen);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
